ehr_reg: RTL and testbench

- Ephemeral History Register (EHR): one N-bit state register with P prioritised write/read ports.
- Lets several rules in one cycle read values forwarded from lower-numbered ports' writes in the same cycle; the last valid write wins at the clock edge.
- Building block for conflict-free FIFOs, pipeline registers and scoreboards in the processor/FIFO library.
- Purely combinational forwarding chain plus one register bank.

---
 rtl/ehr_reg.sv | 35 +++
 tb/tb_ehr_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ehr_reg.sv
// Ephemeral History Register: one N-bit register with P prioritised ports.
// Each port reads the register overridden by the latest valid write from lower-numbered ports.
module ehr_reg #(
  parameter int              N         = 32,
  parameter int              P         = 2,
  parameter logic [N-1:0]    RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [P-1:0][N-1:0] wd,
  input  logic [P-1:0]        wv,
  output logic [P-1:0][N-1:0] r
);

  logic [N-1:0] q;
  logic [N-1:0] fwd;
  logic [N-1:0] nxt;

  // Walk ports in priority order; each port sees the value before its own write.
  always_comb begin
    fwd = q;
    r   = '0;
    for (int i = 0; i < P; i++) begin
      r[i] = fwd;
      if (wv[i]) fwd = wd[i];
    end
    nxt = fwd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RESET_VAL;
    else        q <= nxt;
  end

endmodule

// File: tb/tb_ehr_reg.sv
// Directed self-checking bench for ehr_reg: reset, forwarding, priority, hold, streaming, full width.
// A second instance with a non-zero RESET_VAL checks the reset value parameter.
module tb_ehr_reg;

  logic             clk;
  logic             rst_n;
  logic [1:0][31:0] wd;
  logic [1:0]       wv;
  logic [1:0][31:0] r;
  logic [1:0][31:0] wd_rv;
  logic [1:0]       wv_rv;
  logic [1:0][31:0] r_rv;

  int checks;
  int errors;

  ehr_reg #(.N(32), .P(2), .RESET_VAL(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wd    (wd),
    .wv    (wv),
    .r     (r)
  );

  ehr_reg #(.N(32), .P(2), .RESET_VAL(32'h1234)) dut_rv (
    .clk   (clk),
    .rst_n (rst_n),
    .wd    (wd_rv),
    .wv    (wv_rv),
    .r     (r_rv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
    wv    = v;
    wd[0] = d0;
    wd[1] = d1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge so inputs change away from it.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] prev;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    wv_rv  = 2'b00;
    wd_rv  = '0;
    applyStimulus(2'b11, 32'h77, 32'h88);

    // Mid-cycle asynchronous assertion, before any clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_q",  dut.q, 32'h0);
    checkOutput("rst_async_r0", r[0],  32'h0);
    checkOutput("rst_async_r1", r[1],  32'h77);
    checkOutput("rst_val_r0",   r_rv[0], 32'h1234);

    // Writes during reset are ignored across an edge.
    nextCycle();
    checkOutput("rst_hold_q", dut.q, 32'h0);

    applyStimulus(2'b00, 32'h0, 32'h0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("post_rst_r0", r[0], 32'h0);
      checkOutput("post_rst_r1", r[1], 32'h0);
    end

    applyStimulus(2'b01, 32'h5, 32'h0);
    checkOutput("p0_same_r0", r[0], 32'h0);
    checkOutput("p0_same_r1", r[1], 32'h5);
    nextCycle();
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("p0_after_r0", r[0], 32'h5);
    checkOutput("p0_after_r1", r[1], 32'h5);

    applyStimulus(2'b10, 32'h0, 32'hA);
    checkOutput("p1_same_r0", r[0], 32'h5);
    checkOutput("p1_same_r1", r[1], 32'h5);
    nextCycle();
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("p1_after_r0", r[0], 32'hA);

    applyStimulus(2'b11, 32'h1, 32'h2);
    checkOutput("both_same_r0", r[0], 32'hA);
    checkOutput("both_same_r1", r[1], 32'h1);
    nextCycle();
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("both_after_q",  dut.q, 32'h2);
    checkOutput("both_after_r0", r[0],  32'h2);

    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("hold_r0", r[0], 32'h2);
      checkOutput("hold_r1", r[1], 32'h2);
    end

    prev = 32'h2;
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(2'b01, 32'(c), 32'h0);
      checkOutput("stream_r1", r[1], 32'(c));
      checkOutput("stream_r0", r[0], prev);
      prev = 32'(c);
      nextCycle();
    end
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("stream_end_r0", r[0], 32'h6);

    applyStimulus(2'b10, 32'h0, 32'hFFFF_FFFF);
    wv_rv    = 2'b10;
    wd_rv[1] = 32'hBEEF;
    nextCycle();
    applyStimulus(2'b00, 32'h0, 32'h0);
    wv_rv = 2'b00;
    #1;
    checkOutput("full_r0",    r[0],    32'hFFFF_FFFF);
    checkOutput("full_r1",    r[1],    32'hFFFF_FFFF);
    checkOutput("rv_write_r0", r_rv[0], 32'hBEEF);

    // Second asynchronous reset pulse restores both reset values.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_r0",    r[0],    32'h0);
    checkOutput("rst2_rv_r0", r_rv[0], 32'h1234);
    checkOutput("rst2_rv_r1", r_rv[1], 32'h1234);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rst2_rv_hold", r_rv[0], 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
